// File: rtl/calc_pkg.sv
// Shared calculator definitions: operation codes and the mul/div sequencer state encoding.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL_LOOP = 2'b01,
        DIV_LOOP = 2'b10,
        DONE     = 2'b11
    } seqState_e;

endpackage

// File: rtl/bcd_addsub.sv
// Combinational ripple BCD adder/subtractor; co is the decimal carry (add) or borrow (sub).
module bcd_addsub #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    output logic [4*DIGITS-1:0] y,
    output logic                co
);

    always_comb begin
        logic       c;
        logic [4:0] t;
        c = 1'b0;
        t = '0;
        y = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sub) begin
                t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, c};
                c = t[4];
                if (c) t = t + 5'd10;
            end else begin
                t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
                c = (t > 5'd9);
                if (c) t = t + 5'd6;
            end
            y[4*i +: 4] = t[3:0];
        end
        co = c;
    end

endmodule

// File: rtl/bcd_muldiv_seq.sv
// BCD multiply (repeated add) / divide (repeated subtract) sequencer around one shared BCD add/sub unit.
module bcd_muldiv_seq
    import calc_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [4*DIGITS-1:0]   opA,
    input  logic [4*DIGITS-1:0]   opB,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [8*DIGITS-1:0]   result
);

    localparam int W = 4*DIGITS;

    seqState_e      state, nextState;
    logic [W-1:0]   regA, regB, cnt, rem, q;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] addA, addB, addY;
    logic           addSub, addCo;
    logic           startOk, digitsOk;

    function automatic logic [W-1:0] bcdStep(input logic [W-1:0] v, input logic dec);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (dec) begin
                    if (d == 4'd0) d = 4'd9;
                    else begin d = d - 4'd1; c = 1'b0; end
                end else begin
                    if (d == 4'd9) d = 4'd0;
                    else begin d = d + 4'd1; c = 1'b0; end
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic allBcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    assign startOk  = start && (op == OP_MUL || op == OP_DIV);
    assign digitsOk = allBcd(opA) && allBcd(opB);

    // One adder serves both loops: acc + A when multiplying, rem - B when dividing
    always_comb begin
        addA   = acc;
        addB   = {{W{1'b0}}, regA};
        addSub = 1'b0;
        if (state == DIV_LOOP) begin
            addA   = {{W{1'b0}}, rem};
            addB   = {{W{1'b0}}, regB};
            addSub = 1'b1;
        end
    end

    bcd_addsub #(.DIGITS(2*DIGITS)) uAddSub (
        .a   (addA),
        .b   (addB),
        .sub (addSub),
        .y   (addY),
        .co  (addCo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (startOk) begin
                    if (!digitsOk)        nextState = DONE;
                    else if (op == OP_MUL) nextState = MUL_LOOP;
                    else                   nextState = DIV_LOOP;
                end
            end
            MUL_LOOP: if (cnt == '0) nextState = DONE;
            DIV_LOOP: if (regB == '0 || addCo) nextState = DONE;
            DONE:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    assign busy = (state == MUL_LOOP) || (state == DIV_LOOP);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regA   <= '0;
            regB   <= '0;
            cnt    <= '0;
            rem    <= '0;
            q      <= '0;
            acc    <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startOk) begin
                        regA <= opA;
                        regB <= opB;
                        acc  <= '0;
                        cnt  <= opB;
                        rem  <= opA;
                        q    <= '0;
                        if (!digitsOk) begin
                            err    <= 1'b1;
                            result <= '0;
                        end
                    end
                end
                MUL_LOOP: begin
                    if (cnt == '0) begin
                        result <= acc;
                        err    <= 1'b0;
                    end else begin
                        acc <= addY;
                        cnt <= bcdStep(cnt, 1'b1);
                    end
                end
                DIV_LOOP: begin
                    if (regB == '0) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else if (addCo) begin
                        result <= {q, rem};
                        err    <= 1'b0;
                    end else begin
                        rem <= addY[W-1:0];
                        q   <= bcdStep(q, 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
